// File: rtl/echo_receive_timer_pkg.sv
// Shared types and helpers for the echo receive timer.
//   state_e     : FSM states, encoded as in the transmit counter family
//   score_bits  : width needed to hold a correlator score of 0..n
package echo_receive_timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BLANK  = 3'd1,
        ST_LISTEN = 3'd2,
        ST_DONE   = 3'd3
    } state_e;

    function automatic int unsigned score_bits(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/echo_correlator.sv
// Sliding-window correlator for the received echo bit stream.
//   clk, rst  : clock, asynchronous active-low reset
//   clear     : zero the shift register (takes priority over shift_en)
//   shift_en  : shift din in at the MSB, oldest sample leaves at bit 0
//   din       : synchronized echo sample
//   pattern   : expected pattern, bit 0 received first
//   score     : number of positions where window and pattern agree
module echo_correlator
    import echo_receive_timer_pkg::*;
#(
    parameter int unsigned PULSE_LENGTH = 32,
    localparam int unsigned SCORE_BITS = score_bits(PULSE_LENGTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    shift_en,
    input  logic                    din,
    input  logic [PULSE_LENGTH-1:0] pattern,
    output logic [SCORE_BITS-1:0]   score
);

    logic [PULSE_LENGTH-1:0] sr_q, sr_d;
    logic [PULSE_LENGTH-1:0] agree;

    always_comb begin
        sr_d = sr_q;
        if (clear) begin
            sr_d = '0;
        end else if (shift_en) begin
            sr_d = {din, sr_q[PULSE_LENGTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    always_comb begin
        agree = ~(sr_q ^ pattern);
        score = '0;
        for (int unsigned i = 0; i < PULSE_LENGTH; i++) begin
            score = score + SCORE_BITS'(agree[i]);
        end
    end

endmodule

// File: rtl/echo_receive_timer.sv
// Receive-side time-of-flight timer for the ultrasound link.
// Armed by start_listen, it blanks for blank_count cycles, then correlates the
// synchronized echo against pulse_shape until a match or max_count, and holds
// the result until result_ack.
//   clk, rst         : clock, asynchronous active-low reset
//   start_listen     : arm request (IDLE only)
//   echo_in          : raw asynchronous comparator output
//   pulse_shape      : expected echo pattern, bit 0 first
//   match_threshold  : minimum agreeing bits for detection
//   blank_count      : cycles after arm with matches ignored
//   max_count        : timer value that ends listening
//   result_ack       : consumer accepted the result
//   busy             : blanking or listening
//   result_valid     : result held
//   echo_found, timeout, tof_count, match_score : result fields
module echo_receive_timer
    import echo_receive_timer_pkg::*;
#(
    parameter int unsigned PULSE_LENGTH   = 32,
    parameter int unsigned COUNT_NUM_BITS = 16,
    localparam int unsigned SCORE_BITS = score_bits(PULSE_LENGTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_listen,
    input  logic                      echo_in,
    input  logic [PULSE_LENGTH-1:0]   pulse_shape,
    input  logic [SCORE_BITS-1:0]     match_threshold,
    input  logic [COUNT_NUM_BITS-1:0] blank_count,
    input  logic [COUNT_NUM_BITS-1:0] max_count,
    input  logic                      result_ack,
    output logic                      busy,
    output logic                      result_valid,
    output logic                      echo_found,
    output logic                      timeout,
    output logic [COUNT_NUM_BITS-1:0] tof_count,
    output logic [SCORE_BITS-1:0]     match_score
);

    state_e                    state_q, state_d;
    logic [COUNT_NUM_BITS-1:0] timer_q, timer_d;
    logic [PULSE_LENGTH-1:0]   pulse_q, pulse_d;
    logic [SCORE_BITS-1:0]     thr_q, thr_d;
    logic [COUNT_NUM_BITS-1:0] blank_q, blank_d;
    logic [COUNT_NUM_BITS-1:0] max_q, max_d;
    logic                      echo_found_q, echo_found_d;
    logic                      timeout_q, timeout_d;
    logic [COUNT_NUM_BITS-1:0] tof_q, tof_d;
    logic [SCORE_BITS-1:0]     score_q, score_d;
    logic                      echo_meta_q, echo_meta_d;
    logic                      echo_s_q, echo_s_d;

    logic                      corr_clear;
    logic                      corr_shift;
    logic [SCORE_BITS-1:0]     corr_score;
    logic [COUNT_NUM_BITS-1:0] timer_inc;
    logic                      timer_full;

    echo_correlator #(
        .PULSE_LENGTH(PULSE_LENGTH)
    ) u_corr (
        .clk      (clk),
        .rst      (rst),
        .clear    (corr_clear),
        .shift_en (corr_shift),
        .din      (echo_s_q),
        .pattern  (pulse_q),
        .score    (corr_score)
    );

    assign echo_meta_d = echo_in;
    assign echo_s_d    = echo_meta_q;
    assign timer_inc   = timer_q + COUNT_NUM_BITS'(1);
    assign timer_full  = (timer_q == '1);

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        pulse_d      = pulse_q;
        thr_d        = thr_q;
        blank_d      = blank_q;
        max_d        = max_q;
        echo_found_d = echo_found_q;
        timeout_d    = timeout_q;
        tof_d        = tof_q;
        score_d      = score_q;
        corr_clear   = 1'b0;
        corr_shift   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_listen) begin
                    pulse_d      = pulse_shape;
                    thr_d        = match_threshold;
                    blank_d      = blank_count;
                    max_d        = max_count;
                    timer_d      = '0;
                    corr_clear   = 1'b1;
                    echo_found_d = 1'b0;
                    timeout_d    = 1'b0;
                    tof_d        = '0;
                    score_d      = '0;
                    state_d      = (blank_count == '0) ? ST_LISTEN : ST_BLANK;
                end
            end
            ST_BLANK: begin
                corr_shift = 1'b1;
                timer_d    = timer_inc;
                if (timer_inc == blank_q) begin
                    state_d = ST_LISTEN;
                end
                // Never let the timer wrap while blanking; hand over to LISTEN,
                // which will report the timeout.
                if (timer_full) begin
                    timer_d = timer_q;
                    state_d = ST_LISTEN;
                end
            end
            ST_LISTEN: begin
                corr_shift = 1'b1;
                if (!timer_full) begin
                    timer_d = timer_inc;
                end
                // Match outranks timeout when both occur in the same cycle.
                if (corr_score >= thr_q) begin
                    echo_found_d = 1'b1;
                    tof_d        = timer_q;
                    score_d      = corr_score;
                    state_d      = ST_DONE;
                end else if (timer_q == max_q) begin
                    timeout_d = 1'b1;
                    tof_d     = max_q;
                    score_d   = corr_score;
                    state_d   = ST_DONE;
                end else if (timer_full) begin
                    // max_q was passed during blanking; saturated timer ends listening.
                    timeout_d = 1'b1;
                    tof_d     = timer_q;
                    score_d   = corr_score;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (result_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            pulse_q      <= '0;
            thr_q        <= '0;
            blank_q      <= '0;
            max_q        <= '0;
            echo_found_q <= 1'b0;
            timeout_q    <= 1'b0;
            tof_q        <= '0;
            score_q      <= '0;
            echo_meta_q  <= 1'b0;
            echo_s_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            pulse_q      <= pulse_d;
            thr_q        <= thr_d;
            blank_q      <= blank_d;
            max_q        <= max_d;
            echo_found_q <= echo_found_d;
            timeout_q    <= timeout_d;
            tof_q        <= tof_d;
            score_q      <= score_d;
            echo_meta_q  <= echo_meta_d;
            echo_s_q     <= echo_s_d;
        end
    end

    assign busy         = (state_q == ST_BLANK) || (state_q == ST_LISTEN);
    assign result_valid = (state_q == ST_DONE);
    assign echo_found   = echo_found_q;
    assign timeout      = timeout_q;
    assign tof_count    = tof_q;
    assign match_score  = score_q;

endmodule
